// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the end-of-test monitor.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_GP      = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_HANG    = 2'd3;

  localparam logic [31:0] DEFAULT_DONE_PC    = 32'h44;
  localparam int          DEFAULT_TIMEOUT    = 5000;
  localparam int          DEFAULT_HANG_LIMIT = 64;

endpackage

// File: rtl/test_monitor_hang.sv
// PC hang tracker: counts consecutive cycles where the sampled PC did not move.
module pc_hang_detect #(
  parameter int HANG_LIMIT = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] pc,
  output logic        hang,
  output logic        changed
);

  localparam int HW = $clog2(HANG_LIMIT) + 1;

  logic [31:0]   prev_pc;
  logic          prev_valid;
  logic [HW-1:0] hang_cnt;
  logic          same;

  // Nothing to compare against on the first cycle after clear.
  assign same    = prev_valid && (pc == prev_pc);
  assign changed = prev_valid && (pc != prev_pc);
  assign hang    = same && (hang_cnt == HW'(HANG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      hang_cnt   <= '0;
    end else if (en) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      if (changed)
        hang_cnt <= '0;
      else if (same)
        hang_cnt <= hang_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: decides pass/fail from core PC and gp, with hang and timeout detection.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] DONE_PC    = DEFAULT_DONE_PC,
  parameter int          TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int          HANG_LIMIT = DEFAULT_HANG_LIMIT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic [31:0]      gp,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [31:0]      fail_gp,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] pc_changes
);

  state_t     state, state_nxt;
  logic [1:0] fc_nxt;
  logic       hang, changed, at_done;

  pc_hang_detect #(.HANG_LIMIT(HANG_LIMIT)) u_hang (
    .clk     (clk),
    .clr     (rst),
    .en      (state == ST_RUN),
    .pc      (pc),
    .hang    (hang),
    .changed (changed)
  );

  assign at_done = (pc == DONE_PC);

  // Priority: done beats timeout, timeout beats hang.
  always_comb begin
    state_nxt = state;
    fc_nxt    = FC_NONE;
    if (state == ST_RUN) begin
      if (at_done && gp == 32'd1) begin
        state_nxt = ST_PASS;
      end else if (at_done) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_GP;
      end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_TIMEOUT;
      end else if (hang) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_HANG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= FC_NONE;
      fail_gp    <= '0;
      cycles     <= '0;
      pc_changes <= '0;
    end else if (state == ST_RUN) begin
      cycles <= cycles + 1'b1;
      if (changed)
        pc_changes <= pc_changes + 1'b1;
      if (state_nxt != ST_RUN) begin
        done      <= 1'b1;
        pass      <= (state_nxt == ST_PASS);
        fail_code <= fc_nxt;
        fail_gp   <= gp;
      end
    end
  end

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable end-of-test monitor that sits directly downstream of `Core`. It samples the core's program counter and `gp` (x3) every cycle and decides pass or fail for riscv-tests programs such as rv32ui-p-bge. Pass means the core reached the test's done PC with `gp` == 1. It also detects a hang (PC frozen) and a global timeout, so regressions on FPGA or in lint-clean simulation need no behavioural watcher. The outputs are sticky status plus counters that a bench or a debug UART reads.

## Interface
Parameters:
- `DONE_PC`, 32'h44: PC value at which the test epilogue is reached.
- `TIMEOUT`, 5000: cycles in RUN before a timeout fail; must be ≥ 1 and < 2^CNT_W.
- `HANG_LIMIT`, 64: consecutive cycles with an unchanged PC that count as a hang; must be ≥ 2.
- `CNT_W`, 32: width of the counters.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pc`  in  32: core program counter (`core.pc`).
- `gp`  in  32: core register x3 (`core.rs[3]`).
- `done`  out  1: test finished (pass or fail); sticky.
- `pass`  out  1: finished with pass; only meaningful when `done` = 1.
- `fail_code`  out  2: 0 none, 1 gp mismatch, 2 timeout, 3 hang.
- `fail_gp`  out  32: `gp` captured on the terminal cycle (test number on a riscv-tests fail).
- `cycles`  out  CNT_W: cycles spent in RUN.
- `pc_changes`  out  CNT_W: number of cycles in which `pc` differed from the previous cycle's `pc`.

## Operation
- States: RUN, PASS, FAIL. Reset enters RUN.
- Reset values: `done`=0, `pass`=0, `fail_code`=0, `fail_gp`=0, `cycles`=0, `pc_changes`=0, hang count=0, `prev_valid`=0.
- In RUN, each cycle is evaluated in fixed priority order:
  1. If `pc`==`DONE_PC` and `gp`==1: go to PASS.
  2. If `pc`==`DONE_PC` and `gp`≠1: go to FAIL with code 1.
  3. If `cycles`==`TIMEOUT`-1: go to FAIL with code 2.
  4. If the hang count equals `HANG_LIMIT`-1 and `pc`==`prev_pc`: go to FAIL with code 3.
  5. Otherwise stay in RUN.
- Done beats timeout, and timeout beats hang, when several conditions hit on the same cycle. A pass loop at `DONE_PC` therefore never reports a hang.
- Hang tracking:
  - `prev_pc` is registered every cycle.
  - `prev_valid` is cleared by reset and set after the first RUN cycle.
  - The hang count increments when `prev_valid` is set and `pc`==`prev_pc`.
  - The hang count clears on any PC change; `pc_changes` increments on a PC change.
  - The first cycle after reset counts as neither a change nor a hang.
- `cycles` increments once per RUN cycle, including the terminal cycle.
- Counters cannot wrap: a timeout terminates RUN first. The hang count is log2(HANG_LIMIT)+1 bits.
- On entry to PASS or FAIL: `done` is set, `pass` is set for PASS, `fail_code` and `fail_gp` are latched.
- PASS and FAIL are terminal. All outputs and counters freeze until `rst`.
- `rst` asserted in any state, including mid-RUN, restores every reset value on the next edge.

## Timing
- Inputs are sampled at the rising edge. All outputs are registered.
- A condition present on `pc`/`gp` in cycle N shows on `done`/`pass`/`fail_code` in cycle N+1.
- A timeout asserts `done` exactly `TIMEOUT` edges after the first RUN edge.
- A hang is flagged on the edge where `pc` has been sampled unchanged `HANG_LIMIT` consecutive times.
- There is no handshake: `done` is a level and stays high until reset.
- There is no combinational path from input to output.

## Structure
- Package `test_monitor_pkg`:
  - State encoding: RUN=0, PASS=1, FAIL=2.
  - Fail-code constants: FC_NONE, FC_GP, FC_TIMEOUT, FC_HANG.
  - Default constants: DONE_PC, TIMEOUT, HANG_LIMIT.
- Sub-module `pc_hang_detect` holds `prev_pc`, `prev_valid`, the hang counter and the change pulse.
  - Outputs: `hang` (level) and `changed` (pulse).
  - Its `clr` input is tied to `rst`. The parent gates it by state so it freezes in terminal states.
- Target size: about 150–250 lines of RTL total.

## Test plan
- Pass path:
  - Stimulus: PC steps 0,4,8,…,0x40, then 0x44 with `gp`=1.
  - Required: one cycle later `done`=1, `pass`=1, `fail_code`=0, `cycles`=18, `pc_changes`=17; values hold for 100 further cycles.
- GP mismatch:
  - Stimulus: PC reaches 0x44 with `gp`=5.
  - Required: `done`=1, `pass`=0, `fail_code`=1, `fail_gp`=5.
- Hang:
  - Stimulus: PC toggles for 10 cycles, then holds at 0x100 with `HANG_LIMIT`=64.
  - Required: `fail_code`=3 asserted exactly 64 cycles after PC first reads 0x100.
- Timeout versus done:
  - Stimulus: `TIMEOUT`=20, PC increments every cycle and reaches 0x44 with `gp`=1 on RUN cycle 19 (the timeout cycle).
  - Required: result is PASS, not timeout, and `cycles`=20.
- Timeout only:
  - Stimulus: `TIMEOUT`=20, PC increments every cycle and never reaches `DONE_PC`.
  - Required: `fail_code`=2, `cycles`=20.
- Reset mid-run and after done:
  - Stimulus: assert `rst` at cycle 7 of RUN, and again after PASS.
  - Required: all outputs return to zero the next cycle and counting restarts from 0.
